// File: rtl/candy_alu_seq_pkg.sv
// Shared definitions for the execute-stage sequencer: FSM state encodings,
// ALU opcode constants and the divide-by-zero quotient pattern.
package candy_alu_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_ISSUE   = 3'd1,
        SEQ_CAPT    = 3'd2,
        SEQ_DIV_RUN = 3'd3,
        SEQ_DIV_FIX = 3'd4,
        SEQ_DONE    = 3'd5
    } seq_state_e;

    localparam logic [7:0] EXE_NOP  = 8'h00;
    localparam logic [7:0] EXE_ADD  = 8'h20;
    localparam logic [7:0] EXE_SUB  = 8'h22;
    localparam logic [7:0] EXE_AND  = 8'h24;
    localparam logic [7:0] EXE_OR   = 8'h25;
    localparam logic [7:0] EXE_XOR  = 8'h26;
    localparam logic [7:0] EXE_DIV  = 8'h1A;
    localparam logic [7:0] EXE_DIVU = 8'h1B;

    localparam logic [23:0] DivZeroQuot = 24'hFFFFFF;

    // True for the two opcodes that are routed to the divider instead of the ALU.
    function automatic logic isDivOp(input logic [7:0] op);
        return (op == EXE_DIV) || (op == EXE_DIVU);
    endfunction

endpackage

// File: rtl/candy_alu_seq_if.sv
// Request/result handshake plus ALU drive bus of the execute-stage sequencer.
// master = the pipeline/ALU side, slave = the sequencer.
interface candy_alu_seq_if #(
    parameter int W    = 24,
    parameter int AOPW = 8
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AOPW-1:0] aluop_i;
    logic [W-1:0]    op1_i;
    logic [W-1:0]    op2_i;
    logic            flush_i;
    logic [AOPW-1:0] alu_op_o;
    logic [W-1:0]    alu_reg1_o;
    logic [W-1:0]    alu_reg2_o;
    logic [W-1:0]    alu_res_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [W-1:0]    res_o;
    logic [W-1:0]    rem_o;
    logic            div_err_o;
    logic            stallreq_o;

    modport master (
        output req_valid_i, aluop_i, op1_i, op2_i, flush_i, alu_res_i, res_ready_i,
        input  req_ready_o, alu_op_o, alu_reg1_o, alu_reg2_o, res_valid_o,
               res_o, rem_o, div_err_o, stallreq_o
    );

    modport slave (
        input  req_valid_i, aluop_i, op1_i, op2_i, flush_i, alu_res_i, res_ready_i,
        output req_ready_o, alu_op_o, alu_reg1_o, alu_reg2_o, res_valid_o,
               res_o, rem_o, div_err_o, stallreq_o
    );
endinterface

// File: rtl/candy_alu_seq_div.sv
// candy_div_iter: restoring radix-2 divider, one quotient bit per clock.
// Works on unsigned magnitudes; the signs are re-applied on the outputs.
module candy_div_iter #(
    parameter int W   = 24,
    parameter int CYC = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         start_i,
    input  logic         signed_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);
    localparam int CW = $clog2(CYC + 1);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_divisor;
    logic          r_negQuot;
    logic          r_negRem;
    logic [W-1:0]  w_dividendMag;
    logic [W-1:0]  w_divisorMag;
    logic [W:0]    w_remShift;
    logic [W:0]    w_diff;
    logic          w_fits;

    assign w_dividendMag = (signed_i && dividend_i[W-1]) ? -dividend_i : dividend_i;
    assign w_divisorMag  = (signed_i && divisor_i[W-1])  ? -divisor_i  : divisor_i;
    assign w_remShift    = {r_rem, r_quot[W-1]};
    assign w_diff        = w_remShift - {1'b0, r_divisor};
    assign w_fits        = ~w_diff[W];

    // Load magnitudes on start, then shift/subtract until the counter runs out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (start_i) begin
            r_cnt     <= CW'(CYC);
            r_quot    <= w_dividendMag;
            r_rem     <= '0;
            r_divisor <= w_divisorMag;
            r_negQuot <= signed_i && (dividend_i[W-1] ^ divisor_i[W-1]);
            r_negRem  <= signed_i && dividend_i[W-1];
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_quot <= {r_quot[W-2:0], w_fits};
            r_rem  <= w_fits ? w_diff[W-1:0] : w_remShift[W-1:0];
        end
    end

    assign done_o = (r_cnt == CW'(1));
    assign quot_o = r_negQuot ? -r_quot : r_quot;
    assign rem_o  = r_negRem  ? -r_rem  : r_rem;

endmodule

// File: rtl/candy_alu_seq.sv
// candy_alu_seq: execute-stage sequencer. Issues single-cycle ops to the
// shared ALU and captures its registered result, or runs divisions on the
// iterative divider. Build option CANDY_ALU_SEQ_DIV_EN enables the divider;
// without it DIV/DIVU complete immediately with div_err_o set.
module candy_alu_seq
    import candy_alu_seq_pkg::*;
#(
    parameter int W    = 24,
    parameter int AOPW = 8
) (
    input logic           clk,
    input logic           rst,
    candy_alu_seq_if.slave bus
);
    seq_state_e      r_state;
    seq_state_e      w_nextState;
    logic            w_accept;
    logic [AOPW-1:0] r_aluOp;
    logic [W-1:0]    r_op1;
    logic [W-1:0]    r_op2;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_rem;
    logic            r_err;

`ifdef CANDY_ALU_SEQ_DIV_EN
    localparam int DIV_CYC = W;

    logic            w_divStart;
    logic            w_divDone;
    logic [W-1:0]    w_divQuot;
    logic [W-1:0]    w_divRem;
    logic            r_divZero;

    candy_div_iter #(.W(W), .CYC(DIV_CYC)) u_div (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (bus.flush_i),
        .start_i    (w_divStart),
        .signed_i   (bus.aluop_i == AOPW'(EXE_DIV)),
        .dividend_i (bus.op1_i),
        .divisor_i  (bus.op2_i),
        .done_o     (w_divDone),
        .quot_o     (w_divQuot),
        .rem_o      (w_divRem)
    );
`else
    logic            r_isDiv;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= SEQ_IDLE;
        else      r_state <= w_nextState;
    end

    // Next-state logic; a flush outside IDLE always wins and returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
`ifdef CANDY_ALU_SEQ_DIV_EN
        w_divStart  = 1'b0;
`endif
        case (r_state)
            SEQ_IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    w_accept = 1'b1;
                    if (isDivOp(8'(bus.aluop_i))) begin
`ifdef CANDY_ALU_SEQ_DIV_EN
                        if (bus.op2_i == '0) begin
                            w_nextState = SEQ_DIV_FIX;
                        end else begin
                            w_nextState = SEQ_DIV_RUN;
                            w_divStart  = 1'b1;
                        end
`else
                        w_nextState = SEQ_CAPT;
`endif
                    end else begin
                        w_nextState = SEQ_ISSUE;
                    end
                end
            end
            SEQ_ISSUE: w_nextState = SEQ_CAPT;
            SEQ_CAPT:  w_nextState = SEQ_DONE;
`ifdef CANDY_ALU_SEQ_DIV_EN
            SEQ_DIV_RUN: if (w_divDone) w_nextState = SEQ_DIV_FIX;
            SEQ_DIV_FIX: w_nextState = SEQ_DONE;
`endif
            SEQ_DONE:  if (bus.res_ready_i) w_nextState = SEQ_IDLE;
            default:   w_nextState = SEQ_IDLE;
        endcase
        if (bus.flush_i && (r_state != SEQ_IDLE)) w_nextState = SEQ_IDLE;
    end

    // Operand latch on accept, and result load in CAPT / DIV_FIX unless flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aluOp <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_res   <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
`ifdef CANDY_ALU_SEQ_DIV_EN
            r_divZero <= 1'b0;
`else
            r_isDiv   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_aluOp <= bus.aluop_i;
                r_op1   <= bus.op1_i;
                r_op2   <= bus.op2_i;
`ifdef CANDY_ALU_SEQ_DIV_EN
                r_divZero <= (bus.op2_i == '0);
`else
                r_isDiv   <= isDivOp(8'(bus.aluop_i));
`endif
            end
            if (!bus.flush_i) begin
                case (r_state)
                    SEQ_CAPT: begin
`ifdef CANDY_ALU_SEQ_DIV_EN
                        r_res <= bus.alu_res_i;
                        r_err <= 1'b0;
`else
                        r_res <= r_isDiv ? '0 : bus.alu_res_i;
                        r_err <= r_isDiv;
`endif
                        r_rem <= '0;
                    end
`ifdef CANDY_ALU_SEQ_DIV_EN
                    SEQ_DIV_FIX: begin
                        if (r_divZero) begin
                            r_res <= W'(DivZeroQuot);
                            r_rem <= r_op1;
                            r_err <= 1'b1;
                        end else begin
                            r_res <= w_divQuot;
                            r_rem <= w_divRem;
                            r_err <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.req_ready_o = (r_state == SEQ_IDLE) && !bus.flush_i;
    assign bus.res_valid_o = (r_state == SEQ_DONE);
    assign bus.stallreq_o  = (r_state != SEQ_IDLE) && (r_state != SEQ_DONE);
    assign bus.alu_op_o    = (r_state == SEQ_ISSUE) ? r_aluOp : '0;
    assign bus.alu_reg1_o  = r_op1;
    assign bus.alu_reg2_o  = r_op2;
    assign bus.res_o       = r_res;
    assign bus.rem_o       = r_rem;
    assign bus.div_err_o   = r_err;

endmodule

// File: tb/tb_candy_alu_seq.sv
// Testbench for candy_alu_seq: behavioral registered ALU, scoreboard queue of
// expected results, directed steps. Division steps follow CANDY_ALU_SEQ_DIV_EN.
module tb_candy_alu_seq;
    import candy_alu_seq_pkg::*;

    localparam int W    = 24;
    localparam int AOPW = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         err;
        logic [7:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sbQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    candy_alu_seq_if #(.W(W), .AOPW(AOPW)) bus();

    candy_alu_seq #(.W(W), .AOPW(AOPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference for the shared ALU's combinational function.
    function automatic logic [W-1:0] aluModel(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            EXE_AND: return a & b;
            EXE_OR:  return a | b;
            EXE_XOR: return a ^ b;
            EXE_ADD: return a + b;
            EXE_SUB: return a - b;
            default: return '0;
        endcase
    endfunction

    // Behavioral ALU with its one-cycle result register.
    always @(posedge clk) begin
        bus.alu_res_i <= aluModel(bus.alu_op_o, bus.alu_reg1_o, bus.alu_reg2_o);
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for one cycle; optionally record the expected result.
    task automatic applyStimulus(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eRes, input logic [W-1:0] eRem, input logic eErr,
                                 input int lat, input string tag, input bit push);
        exp_t e;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.aluop_i     = op;
        bus.op1_i       = a;
        bus.op2_i       = b;
        checkVal({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        if (push) begin
            e.res = eRes; e.rem = eRem; e.err = eErr;
            e.op = op; e.a = a; e.b = b; e.lat = lat; e.tag = tag;
            sbQ.push_back(e);
        end
    endtask

    // Wait (bounded) for the result, compare it, hold it under backpressure, take it.
    task automatic checkOutput(input int maxCycles, input int holdCycles);
        exp_t e;
        int   n = 0;
        bit   seen = 1'b0;
        if (sbQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sbQ.pop_front();
        while (n < maxCycles && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.res_valid_o;
            if (n == 1)
                checkVal({e.tag, "_alu_op_c1"}, 32'(bus.alu_op_o), isDivOp(e.op) ? 32'd0 : 32'(e.op));
            if (!seen) checkVal({e.tag, "_stall"}, 32'(bus.stallreq_o), 32'd1);
        end
        checkVal({e.tag, "_valid_seen"}, 32'(seen), 32'd1);
        checkVal({e.tag, "_latency"}, 32'(n), 32'(e.lat));
        checkVal({e.tag, "_res"}, 32'(bus.res_o), 32'(e.res));
        checkVal({e.tag, "_rem"}, 32'(bus.rem_o), 32'(e.rem));
        checkVal({e.tag, "_err"}, 32'(bus.div_err_o), 32'(e.err));
        checkVal({e.tag, "_stall_done"}, 32'(bus.stallreq_o), 32'd0);
        checkVal({e.tag, "_alu_op_done"}, 32'(bus.alu_op_o), 32'd0);
        checkVal({e.tag, "_reg1_hold"}, 32'(bus.alu_reg1_o), 32'(e.a));
        checkVal({e.tag, "_reg2_hold"}, 32'(bus.alu_reg2_o), 32'(e.b));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkVal({e.tag, "_bp_valid"}, 32'(bus.res_valid_o), 32'd1);
            checkVal({e.tag, "_bp_res"}, 32'(bus.res_o), 32'(e.res));
            checkVal({e.tag, "_bp_ready"}, 32'(bus.req_ready_o), 32'd0);
        end
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready_i = 1'b0;
        @(negedge clk);
        checkVal({e.tag, "_valid_drop"}, 32'(bus.res_valid_o), 32'd0);
        checkVal({e.tag, "_ready_back"}, 32'(bus.req_ready_o), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        bit sawValid;
        bus.req_valid_i = 1'b0;
        bus.aluop_i     = '0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.flush_i     = 1'b0;
        bus.res_ready_i = 1'b0;
        rst             = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkVal("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        checkVal("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        checkVal("rst_res", 32'(bus.res_o), 32'd0);
        checkVal("rst_rem", 32'(bus.rem_o), 32'd0);
        checkVal("rst_err", 32'(bus.div_err_o), 32'd0);
        checkVal("rst_stall", 32'(bus.stallreq_o), 32'd0);
        checkVal("rst_alu_op", 32'(bus.alu_op_o), 32'd0);
        checkVal("rst_reg1", 32'(bus.alu_reg1_o), 32'd0);
        checkVal("rst_reg2", 32'(bus.alu_reg2_o), 32'd0);

        bus.flush_i = 1'b1;
        #1;
        checkVal("idle_flush_blocks_ready", 32'(bus.req_ready_o), 32'd0);
        bus.flush_i = 1'b0;

        $display("[TB] ALU ops");
        applyStimulus(EXE_AND, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, '0, 1'b0, 3, "and_bp", 1'b1);
        checkOutput(10, 5);
        applyStimulus(EXE_OR, 24'h123400, 24'h000056, aluModel(EXE_OR, 24'h123400, 24'h000056), '0, 1'b0, 3, "or", 1'b1);
        checkOutput(10, 0);
        applyStimulus(EXE_ADD, 24'hFFFFFF, 24'h000002, aluModel(EXE_ADD, 24'hFFFFFF, 24'h000002), '0, 1'b0, 3, "add_wrap", 1'b1);
        checkOutput(10, 0);
        applyStimulus(8'h7F, 24'h111111, 24'h222222, 24'h000000, '0, 1'b0, 3, "unknown_op", 1'b1);
        checkOutput(10, 0);

`ifdef CANDY_ALU_SEQ_DIV_EN
        $display("[TB] divider");
        applyStimulus(EXE_DIV, 24'hFFFFF9, 24'h000002, 24'hFFFFFD, 24'hFFFFFF, 1'b0, 26, "div_neg7_2", 1'b1);
        checkOutput(40, 0);
        applyStimulus(EXE_DIVU, 24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 26, "divu_100_7", 1'b1);
        checkOutput(40, 0);
        applyStimulus(EXE_DIV, 24'd7, 24'hFFFFFE, 24'hFFFFFD, 24'd1, 1'b0, 26, "div_7_neg2", 1'b1);
        checkOutput(40, 0);
        applyStimulus(EXE_DIV, 24'h800000, 24'hFFFFFF, 24'h800000, 24'd0, 1'b0, 26, "div_ovf", 1'b1);
        checkOutput(40, 0);
        applyStimulus(EXE_DIVU, 24'd5, 24'd0, DivZeroQuot, 24'd5, 1'b1, 2, "divu_by0", 1'b1);
        checkOutput(10, 0);

        $display("[TB] flush during divide");
        applyStimulus(EXE_DIVU, 24'd1000, 24'd3, '0, '0, 1'b0, 0, "flush_div", 1'b0);
        repeat (9) @(negedge clk);
`else
        $display("[TB] divider disabled");
        applyStimulus(EXE_DIV, 24'd9, 24'd3, 24'd0, 24'd0, 1'b1, 2, "nodiv_9_3", 1'b1);
        checkOutput(10, 0);
        applyStimulus(EXE_DIVU, 24'd5, 24'd0, 24'd0, 24'd0, 1'b1, 2, "nodiv_by0", 1'b1);
        checkOutput(10, 0);

        $display("[TB] flush during ALU op");
        applyStimulus(EXE_AND, 24'hFFFFFF, 24'h00FF00, '0, '0, 1'b0, 0, "flush_alu", 1'b0);
`endif
        @(negedge clk);
        checkVal("flush_pre_stall", 32'(bus.stallreq_o), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checkVal("flush_idle_stall", 32'(bus.stallreq_o), 32'd0);
        checkVal("flush_idle_ready", 32'(bus.req_ready_o), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid_o) sawValid = 1'b1;
        end
        checkVal("flush_no_result", 32'(sawValid), 32'd0);

        applyStimulus(EXE_AND, 24'hABCDEF, 24'h0F0F0F, 24'h0B0D0F, '0, 1'b0, 3, "and_after_flush", 1'b1);
        checkOutput(10, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(EXE_XOR, 24'h00FFFF, 24'h0F0F0F, '0, '0, 1'b0, 0, "rst_mid", 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkVal("rst_mid_stall", 32'(bus.stallreq_o), 32'd0);
        checkVal("rst_mid_alu_op", 32'(bus.alu_op_o), 32'd0);
        checkVal("rst_mid_reg1", 32'(bus.alu_reg1_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkVal("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
        checkVal("rst_mid_valid", 32'(bus.res_valid_o), 32'd0);

        applyStimulus(EXE_SUB, 24'h000010, 24'h000011, aluModel(EXE_SUB, 24'h000010, 24'h000011), '0, 1'b0, 3, "sub_after_rst", 1'b1);
        checkOutput(10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
